muldivunit: RTL

Multi-cycle signed multiply/divide unit with HI/LO registers; the consumer end of the 6-bit `AluCtrl` bus produced by the ALU control decoder. It executes `mult`/`div` iteratively over `WIDTH` cycles, holds results in HI/LO and serves `mfhi`/`mflo` reads. A `Stall` output lets the pipeline freeze the issuing stage while a HI/LO-dependent instruction waits.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_signfix.sv | 13 +
 rtl/muldivunit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// AluCtrl encodings, FSM state codes and counter sizing.
package muldiv_pkg;

    localparam logic [5:0] ALU_MULT = 6'b001000;
    localparam logic [5:0] ALU_DIV  = 6'b001010;
    localparam logic [5:0] ALU_MFHI = 6'b001111;
    localparam logic [5:0] ALU_MFLO = 6'b000001;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation; used both to take operand
// magnitudes and to restore result signs.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldivunit.sv
// Multi-cycle signed mult/div with HI/LO registers: one bit per cycle,
// followed by a single sign-fixup cycle.
module muldivunit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       AluCtrl,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic [WIDTH-1:0] HiLoOut
);

    localparam int W  = WIDTH;
    localparam int CW = cnt_width(WIDTH);

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic           is_div;
    logic           div_zero;
    logic           sign_q;
    logic           sign_r;
    logic [W-1:0]   dsr;
    logic [2*W-1:0] acc;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           done;

    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic           op_mult;
    logic           op_div;
    logic           accept;

    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh;
    logic [W:0]     diff;
    logic           take;
    logic [2*W-1:0] step_acc;

    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo_s;
    logic [W-1:0]   rem_s;

    muldiv_signfix #(.W(W)) u_mag_a (
        .value(A), .negate(A[W-1]), .result(mag_a)
    );
    muldiv_signfix #(.W(W)) u_mag_b (
        .value(B), .negate(B[W-1]), .result(mag_b)
    );
    muldiv_signfix #(.W(2*W)) u_fix_prod (
        .value(acc), .negate(sign_q), .result(prod_s)
    );
    muldiv_signfix #(.W(W)) u_fix_quo (
        .value(acc[W-1:0]), .negate(sign_q), .result(quo_s)
    );
    muldiv_signfix #(.W(W)) u_fix_rem (
        .value(acc[2*W-1:W]), .negate(sign_r), .result(rem_s)
    );

    assign op_mult = (AluCtrl == ALU_MULT);
    assign op_div  = (AluCtrl == ALU_DIV);
    assign accept  = Start && (state == S_IDLE) && (op_mult || op_div);

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum = {1'b0, acc[2*W-1:W]}
                   + (acc[0] ? {1'b0, dsr} : {(W+1){1'b0}});

    // Divide: acc = {partial remainder, remaining dividend/quotient bits}
    assign rem_sh = {acc[2*W-1:W], acc[W-1]};
    assign diff   = rem_sh - {1'b0, dsr};
    assign take   = ~diff[W];

    assign step_acc = is_div
        ? {(take ? diff[W-1:0] : rem_sh[W-1:0]), acc[W-2:0], take}
        : {mul_sum, acc[W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dsr      <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= op_div ? S_DIV : S_MUL;
                        is_div   <= op_div;
                        cnt      <= '0;
                        sign_q   <= A[W-1] ^ B[W-1];
                        sign_r   <= A[W-1];
                        div_zero <= op_div && (B == '0);
                        dsr      <= op_div ? mag_b : mag_a;
                        acc      <= {{W{1'b0}}, (op_div ? mag_a : mag_b)};
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= step_acc;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        // Zero divisor leaves |A| as remainder, so HI
                        // naturally becomes A; only LO needs forcing.
                        lo <= div_zero ? {W{1'b1}} : quo_s;
                        hi <= rem_s;
                    end else begin
                        lo <= prod_s[W-1:0];
                        hi <= prod_s[2*W-1:W];
                    end
                    done  <= 1'b1;
                    cnt   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Busy  = (state != S_IDLE);
    assign Done  = done;
    assign Stall = Busy && (op_mult || op_div
                         || AluCtrl == ALU_MFHI || AluCtrl == ALU_MFLO);

    always_comb begin
        HiLoOut = '0;
        if (AluCtrl == ALU_MFHI) HiLoOut = hi;
        else if (AluCtrl == ALU_MFLO) HiLoOut = lo;
    end

endmodule
